alloc_stack: RTL
================

Name: alloc_stack

Overview:
- LIFO stack of 8-bit values built as a linked list in the linked-memory allocator's RAM; sits directly upstream of alloc and drives its alloc/free/read ports.
- Each node is one allocated cell holding {next_offset[7:0], data[7:0]}. Push allocates a node and pop reads then frees it.
- A one-command-at-a-time interface is used by test fixtures and by future list-processing logic.

Parameters:
- BASE, 16'h5000, RAM address of cell offset 0; node addresses are {BASE[15:8], offset[7:0]}.
- DEPTH, 256, maximum number of nodes; push is rejected at this depth.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_push  in  1  push request, sampled only while o_ready=1
- i_pop  in  1  pop request, sampled only while o_ready=1
- i_data  in  8  value to push
- o_ready  out  1  idle, command accepted this cycle
- o_valid  out  1  one-cycle pulse; o_data holds popped value
- o_data  out  8  popped value, held until next pop completes
- o_empty  out  1  depth==0
- o_full  out  1  depth==DEPTH
- o_depth  out  9  current node count
- o_error  out  1  one-cycle pulse on rejected command
- o_al  out  1  alloc strobe to allocator
- o_adata  out  16  alloc data {top_offset, i_data}
- i_aaddr  in  16  allocator result, valid cycle after o_al
- o_fr  out  1  free strobe
- o_faddr  out  16  address to free
- o_rd  out  1  read strobe
- o_raddr  out  16  read address
- i_rdata  in  16  read data, valid cycle after o_rd

Behaviour:
- Reset: state IDLE, top=0, depth=0, o_valid=0, o_error=0, o_data=0, o_ready=1, o_empty=1, o_full=0. All allocator strobes are 0.
- Reset mid-operation abandons the in-flight op. Allocated cells are leaked because the allocator has no reset; the bench must not rely on their reuse.
- Allocator strobes are combinational from state, the accepted command and registers. o_valid, o_error, o_data and o_depth are registered.
- IDLE, i_push only, not full (cycle T):
  - o_al=1, o_adata={top, i_data}.
  - Go to PUSH_WAIT.
  - When depth==0 the link byte is top's stale value, which is don't-care.
- PUSH_WAIT (T+1):
  - If i_aaddr[15:8]==BASE[15:8]: top<=i_aaddr[7:0], depth+1.
  - Otherwise: o_error pulse at T+2, top and depth unchanged, and the cell is not freed.
  - Go to IDLE, so o_ready=1 at T+2.
- IDLE, i_pop only, not empty (cycle T):
  - o_rd=1, o_raddr={BASE[15:8], top}.
  - Go to POP_READ.
- POP_READ (T+1):
  - o_fr=1, o_faddr={BASE[15:8], old top}.
  - o_data<=i_rdata[7:0], top<=i_rdata[15:8], depth-1.
  - o_valid=1 at T+2, with IDLE/o_ready at T+2.
- Rejected commands get an o_error pulse next cycle, stay in IDLE, and change no state. Cases:
  - push while full
  - pop while empty
  - push and pop in the same cycle
- Commands presented while o_ready=0 are ignored without error.
- Never asserts more than one of o_al/o_fr/o_rd in a cycle. o_wr is not driven because the block has no write port.
- Throughput: one op per 2 cycles. Depth wraps never: it saturates by rule via the full/empty rejection.

Test Plan:
- Reset, then pop -> o_error=1 one cycle later; o_depth=0, o_empty=1, no o_rd/o_fr issued.
- Fresh allocator, push 8'h11, 8'h22, 8'h33 -> o_adata is {xx,11}, {top1,22}, {top2,33}, where top1/top2 equal the low bytes of the prior i_aaddr; o_depth=3.
- Continue with three pops -> o_valid pulses with o_data=33, 22, 11.
  - Each o_raddr equals the matching push's i_aaddr, and o_faddr equals that address one cycle later.
  - Ends with o_empty=1.
- Drive i_push and i_pop together in IDLE with depth=1 -> o_error pulse, depth stays 1, no allocator strobe.
- DEPTH=4 build: push 4 values, then a 5th -> o_full=1, 5th gives o_error with no o_al. Pop -> last pushed value returned, o_full=0.
- Push, then assert i_rst during PUSH_WAIT -> next cycle IDLE, depth=0, o_ready=1. A subsequent push/pop pair round-trips its value correctly.

Source files
------------

// File: rtl/alloc_stack.sv
// rtl/alloc_stack.sv - LIFO stack of bytes kept as a linked list in allocator RAM
module alloc_stack #(
    parameter logic [15:0] BASE  = 16'h5000,
    parameter int unsigned DEPTH = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [7:0]  i_data,
    output logic        o_ready,
    output logic        o_valid,
    output logic [7:0]  o_data,
    output logic        o_empty,
    output logic        o_full,
    output logic [8:0]  o_depth,
    output logic        o_error,
    output logic        o_al,
    output logic [15:0] o_adata,
    input  logic [15:0] i_aaddr,
    output logic        o_fr,
    output logic [15:0] o_faddr,
    output logic        o_rd,
    output logic [15:0] o_raddr,
    input  logic [15:0] i_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PUSH_WAIT = 2'd1,
        POP_READ  = 2'd2
    } state_t;

    localparam logic [7:0] BASE_HI   = BASE[15:8];
    localparam logic [8:0] DEPTH_MAX = DEPTH[8:0];

    state_t      state_q, state_d;
    logic [7:0]  top_q, top_d;
    logic [8:0]  depth_q, depth_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic [7:0]  data_q, data_d;

    logic        idle;
    logic        empty;
    logic        full;
    logic        push_ok;
    logic        pop_ok;

    assign idle    = (state_q == IDLE);
    assign empty   = (depth_q == 9'd0);
    assign full    = (depth_q == DEPTH_MAX);
    assign push_ok = idle && i_push && !i_pop && !full;
    assign pop_ok  = idle && i_pop && !i_push && !empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            top_q   <= 8'd0;
            depth_q <= 9'd0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            top_q   <= top_d;
            depth_q <= depth_d;
            valid_q <= valid_d;
            error_q <= error_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        top_d   = top_q;
        depth_d = depth_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (push_ok) begin
                    state_d = PUSH_WAIT;
                end else if (pop_ok) begin
                    state_d = POP_READ;
                end else if (i_push || i_pop) begin
                    error_d = 1'b1;
                end
            end
            PUSH_WAIT: begin
                state_d = IDLE;
                // An address outside our RAM page cannot be linked; that cell is leaked.
                if (i_aaddr[15:8] == BASE_HI) begin
                    top_d   = i_aaddr[7:0];
                    depth_d = depth_q + 9'd1;
                end else begin
                    error_d = 1'b1;
                end
            end
            POP_READ: begin
                state_d = IDLE;
                data_d  = i_rdata[7:0];
                top_d   = i_rdata[15:8];
                depth_d = depth_q - 9'd1;
                valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_al    = push_ok;
        o_rd    = pop_ok;
        o_fr    = (state_q == POP_READ);
        o_adata = {top_q, i_data};
        o_raddr = {BASE_HI, top_q};
        o_faddr = {BASE_HI, top_q};
    end

    assign o_ready = idle;
    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_empty = empty;
    assign o_full  = full;
    assign o_depth = depth_q;
    assign o_error = error_q;

endmodule
